// File: rtl/pauli_gate_engine.sv
// -----------------------------------------------------------------------------
// pauli_gate_engine
//
// Applies one Pauli-family gate (X, Y, Z, S, S-dagger, CNOT, CZ) to the
// statevector held in an external dual-port memory. Every supported gate is a
// permutation, sign flip or re/im swap, so the datapath is only muxes and
// sign-bit inverters.
//
// Operation: the engine walks amplitude pairs (i, j), where j = i | (1<<target).
// For each pair it reads both amplitudes (port A: i, port B: j), captures them,
// then writes the updated pair back through port A in two cycles.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. cmd_op, cmd_target
// and cmd_control are captured on that edge. cmd_valid is ignored while busy.
// done pulses for one cycle at completion; err is meaningful only with done.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          gate command handshake
//   cmd_op/cmd_target/cmd_control  gate opcode and qubit indices
//   done, err                    completion pulse and reject flag
//   porta_en/we/addr/din_re/im   memory port A (read/write)
//   porta_dout_re/im             port A read data (1-cycle latency)
//   portb_en/addr                memory port B (read-only)
//   portb_dout_re/im             port B read data (1-cycle latency)
//   dbg_state                    current FSM state encoding
// -----------------------------------------------------------------------------
module pauli_gate_engine #(
  parameter int NUM_QUBITS      = 3,
  parameter int AMPLITUDE_WIDTH = 32,
  localparam int NUM_STATES     = 1 << NUM_QUBITS,
  localparam int QW             = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1,
  localparam int AW             = $clog2(NUM_STATES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [QW-1:0]              cmd_target,
  input  logic [QW-1:0]              cmd_control,
  output logic                       done,
  output logic                       err,
  output logic                       porta_en,
  output logic                       porta_we,
  output logic [AW-1:0]              porta_addr,
  output logic [AMPLITUDE_WIDTH-1:0] porta_din_re,
  output logic [AMPLITUDE_WIDTH-1:0] porta_din_im,
  input  logic [AMPLITUDE_WIDTH-1:0] porta_dout_re,
  input  logic [AMPLITUDE_WIDTH-1:0] porta_dout_im,
  output logic                       portb_en,
  output logic [AW-1:0]              portb_addr,
  input  logic [AMPLITUDE_WIDTH-1:0] portb_dout_re,
  input  logic [AMPLITUDE_WIDTH-1:0] portb_dout_im,
  output logic [2:0]                 dbg_state
);

  localparam int W  = AMPLITUDE_WIDTH;
  localparam int KW = (AW > 1) ? AW - 1 : 1;

  localparam logic [AW-1:0] ONE_AW   = AW'(1);
  localparam logic [QW:0]   NQ       = (QW + 1)'(NUM_QUBITS);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STATES / 2 - 1);

  typedef enum logic [2:0] {
    OP_X   = 3'd0,
    OP_Y   = 3'd1,
    OP_Z   = 3'd2,
    OP_S   = 3'd3,
    OP_SDG = 3'd4,
    OP_CNOT= 3'd5,
    OP_CZ  = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_RD     = 3'd2,
    S_LAT    = 3'd3,
    S_WR0    = 3'd4,
    S_WR1    = 3'd5,
    S_DONE   = 3'd6,
    S_REJECT = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [QW-1:0]   tgt_q, tgt_d;
  logic [QW-1:0]   ctl_q, ctl_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a0_re_q, a0_im_q, a1_re_q, a1_im_q;
  logic [W-1:0]    a0_re_d, a0_im_d, a1_re_d, a1_im_d;

  logic [AW-1:0]   k_ext, low_mask, i_addr, j_addr;
  logic            ctrl_op, cmd_bad, k_last;
  logic [W-1:0]    n0_re, n0_im, n1_re, n1_im;

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return {~x[W-1], x[W-2:0]};
  endfunction

  assign dbg_state = state_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign ctrl_op   = (op_q == OP_CNOT) || (op_q == OP_CZ);
  assign k_last    = (k_q == K_LAST);

  // i = k with a zero inserted at bit 'target'; j sets that bit.
  assign k_ext    = {1'b0, k_q};
  assign low_mask = (ONE_AW << tgt_q) - ONE_AW;
  assign i_addr   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
  assign j_addr   = i_addr | (ONE_AW << tgt_q);

  assign cmd_bad = (op_q == OP_RSV) ||
                   ({1'b0, tgt_q} >= NQ) ||
                   (ctrl_op && (({1'b0, ctl_q} >= NQ) || (ctl_q == tgt_q)));

  // Updated pair, derived from the captured amplitudes a0 (at i) and a1 (at j).
  always_comb begin
    n0_re = a0_re_q;
    n0_im = a0_im_q;
    n1_re = a1_re_q;
    n1_im = a1_im_q;
    case (op_q)
      OP_X, OP_CNOT: begin
        n0_re = a1_re_q;      n0_im = a1_im_q;
        n1_re = a0_re_q;      n1_im = a0_im_q;
      end
      OP_Y: begin
        n0_re = a1_im_q;      n0_im = neg(a1_re_q);
        n1_re = neg(a0_im_q); n1_im = a0_re_q;
      end
      OP_Z, OP_CZ: begin
        n1_re = neg(a1_re_q); n1_im = neg(a1_im_q);
      end
      OP_S: begin
        n1_re = neg(a1_im_q); n1_im = a1_re_q;
      end
      OP_SDG: begin
        n1_re = a1_im_q;      n1_im = neg(a1_re_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tgt_d        = tgt_q;
    ctl_d        = ctl_q;
    k_d          = k_q;
    a0_re_d      = a0_re_q;
    a0_im_d      = a0_im_q;
    a1_re_d      = a1_re_q;
    a1_im_d      = a1_im_q;
    done         = 1'b0;
    err          = 1'b0;
    porta_en     = 1'b0;
    porta_we     = 1'b0;
    porta_addr   = '0;
    porta_din_re = '0;
    porta_din_im = '0;
    portb_en     = 1'b0;
    portb_addr   = '0;

    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          tgt_d   = cmd_target;
          ctl_d   = cmd_control;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = cmd_bad ? S_REJECT : S_RD;
      end
      S_RD: begin
        if (ctrl_op && !i_addr[ctl_q]) begin
          // Control qubit is 0 for this pair: nothing to do, one cycle per skip.
          k_d = k_q + 1'b1;
          if (k_last) state_d = S_DONE;
        end else begin
          porta_en   = 1'b1;
          porta_addr = i_addr;
          portb_en   = 1'b1;
          portb_addr = j_addr;
          state_d    = S_LAT;
        end
      end
      S_LAT: begin
        a0_re_d = porta_dout_re;
        a0_im_d = porta_dout_im;
        a1_re_d = portb_dout_re;
        a1_im_d = portb_dout_im;
        state_d = S_WR0;
      end
      S_WR0: begin
        porta_en     = 1'b1;
        porta_we     = 1'b1;
        porta_addr   = i_addr;
        porta_din_re = n0_re;
        porta_din_im = n0_im;
        state_d      = S_WR1;
      end
      S_WR1: begin
        porta_en     = 1'b1;
        porta_we     = 1'b1;
        porta_addr   = j_addr;
        porta_din_re = n1_re;
        porta_din_im = n1_im;
        k_d          = k_q + 1'b1;
        state_d      = k_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_REJECT: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tgt_q   <= '0;
      ctl_q   <= '0;
      k_q     <= '0;
      a0_re_q <= '0;
      a0_im_q <= '0;
      a1_re_q <= '0;
      a1_im_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      ctl_q   <= ctl_d;
      k_q     <= k_d;
      a0_re_q <= a0_re_d;
      a0_im_q <= a0_im_d;
      a1_re_q <= a1_re_d;
      a1_im_q <= a1_im_d;
    end
  end

endmodule

// File: tb/tb_pauli_gate_engine.sv
// -----------------------------------------------------------------------------
// tb_pauli_gate_engine
//
// Directed bench for pauli_gate_engine with NUM_QUBITS=3. A behavioural
// dual-port memory with 1-cycle synchronous reads sits behind the engine.
// Each test task preloads the memory, issues a gate and compares final
// memory contents, latency and port activity against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pauli_gate_engine;

  localparam int W  = 32;
  localparam int AW = 3;
  localparam int QW = 2;

  localparam logic [W-1:0] ONE  = 32'h3f800000;
  localparam logic [W-1:0] HALF = 32'h3f000000;
  localparam logic [W-1:0] MONE = 32'hbf800000;
  localparam logic [W-1:0] MHLF = 32'hbf000000;
  localparam logic [W-1:0] NZ   = 32'h80000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           cmd_valid, cmd_ready;
  logic [2:0]     cmd_op;
  logic [QW-1:0]  cmd_target, cmd_control;
  logic           done, err;
  logic           porta_en, porta_we, portb_en;
  logic [AW-1:0]  porta_addr, portb_addr;
  logic [W-1:0]   porta_din_re, porta_din_im;
  logic [W-1:0]   porta_dout_re, porta_dout_im, portb_dout_re, portb_dout_im;
  logic [2:0]     dbg_state;

  pauli_gate_engine #(.NUM_QUBITS(3), .AMPLITUDE_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_target(cmd_target), .cmd_control(cmd_control),
    .done(done), .err(err),
    .porta_en(porta_en), .porta_we(porta_we), .porta_addr(porta_addr),
    .porta_din_re(porta_din_re), .porta_din_im(porta_din_im),
    .porta_dout_re(porta_dout_re), .porta_dout_im(porta_dout_im),
    .portb_en(portb_en), .portb_addr(portb_addr),
    .portb_dout_re(portb_dout_re), .portb_dout_im(portb_dout_im),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [W-1:0]  mem_re [8];
  logic [W-1:0]  mem_im [8];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_re, ld_im;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_re[ld_addr] <= ld_re;
      mem_im[ld_addr] <= ld_im;
    end else if (porta_en && porta_we) begin
      mem_re[porta_addr] <= porta_din_re;
      mem_im[porta_addr] <= porta_din_im;
    end
    if (porta_en && !porta_we) begin
      porta_dout_re <= mem_re[porta_addr];
      porta_dout_im <= mem_im[porta_addr];
    end
    if (portb_en) begin
      portb_dout_re <= mem_re[portb_addr];
      portb_dout_im <= mem_im[portb_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic mem_set(input logic [AW-1:0] a, input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_re = re; ld_im = im;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic mem_clear();
    for (int a = 0; a < 8; a++) mem_set(AW'(a), '0, '0);
  endtask

  // Issues one command and waits for done (budget 100 cycles). cyc is the
  // cycle index (1 = first cycle after acceptance) where done was seen, -1 on
  // timeout. cmd_valid stays high with a junk opcode while busy.
  task automatic run_cmd(input logic [2:0] op, input logic [QW-1:0] t, input logic [QW-1:0] c,
                         output int cyc, output logic e, output int en_cnt,
                         output int we_cnt, output int rdy_busy);
    cyc = -1; e = 1'b0; en_cnt = 0; we_cnt = 0; rdy_busy = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = t; cmd_control = c;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin cmd_op = 3'd7; cmd_target = 2'd3; end
      if (porta_en || portb_en) en_cnt++;
      if (porta_we) we_cnt++;
      if (cmd_ready) rdy_busy++;
      if (done) begin
        cyc = n; e = err;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_target = '0; cmd_control = '0;
    ld_en = 1'b0; ld_addr = '0; ld_re = '0; ld_im = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b done=%b err=%b state=%0d required 1 0 0 0",
               cmd_ready, done, err, dbg_state);
    end
    checks++;
    if (porta_en !== 1'b0 || porta_we !== 1'b0 || portb_en !== 1'b0 ||
        porta_addr !== '0 || portb_addr !== '0 || porta_din_re !== '0 || porta_din_im !== '0) begin
      failures++;
      $display("FAIL reset_ports: aen=%b we=%b ben=%b aaddr=%0d baddr=%0d din=%h/%h required all 0",
               porta_en, porta_we, portb_en, porta_addr, portb_addr, porta_din_re, porta_din_im);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_x();
    int cyc, en, we, rb; logic e;
    mem_clear();
    mem_set(3'd0, ONE, '0);
    run_cmd(3'd0, 2'd0, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (cyc !== 18 || e !== 1'b0) begin
      failures++; $display("FAIL x_latency: cycles=%0d err=%b required 18 0", cyc, e);
    end
    checks++;
    if (en !== 12 || we !== 8 || rb !== 0) begin
      failures++; $display("FAIL x_ports: en=%0d we=%0d ready_busy=%0d required 12 8 0", en, we, rb);
    end
    checks++;
    for (int a = 0; a < 8; a++) begin
      logic [W-1:0] exp_re;
      exp_re = (a == 1) ? ONE : '0;
      if (mem_re[a] !== exp_re || mem_im[a] !== '0) begin
        failures++;
        $display("FAIL x_mem[%0d]: got %h/%h required %h/0", a, mem_re[a], mem_im[a], exp_re);
      end
    end
    // One-cycle done pulse, then IDLE.
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL x_after_done: done=%b ready=%b required 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_x_cnot();
    int cyc, en, we, rb; logic e;
    mem_clear();
    mem_set(3'd0, ONE, '0);
    run_cmd(3'd0, 2'd1, 2'd0, cyc, e, en, we, rb);
    run_cmd(3'd5, 2'd2, 2'd1, cyc, e, en, we, rb);
    checks++;
    if (cyc !== 12 || e !== 1'b0 || we !== 4 || en !== 6) begin
      failures++;
      $display("FAIL cnot_walk: cycles=%0d err=%b we=%0d en=%0d required 12 0 4 6", cyc, e, we, en);
    end
    checks++;
    for (int a = 0; a < 8; a++) begin
      logic [W-1:0] exp_re;
      exp_re = (a == 6) ? ONE : '0;
      if (mem_re[a] !== exp_re || mem_im[a] !== '0) begin
        failures++;
        $display("FAIL cnot_mem[%0d]: got %h/%h required %h/0", a, mem_re[a], mem_im[a], exp_re);
      end
    end
  endtask

  task automatic test_s_sdg();
    int cyc, en, we, rb; logic e;
    mem_clear();
    mem_set(3'd4, HALF, ONE);
    run_cmd(3'd3, 2'd2, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (cyc !== 18 || mem_re[4] !== MONE || mem_im[4] !== HALF) begin
      failures++;
      $display("FAIL s_amp4: cycles=%0d got %h/%h required 18 bf800000/3f000000", cyc, mem_re[4], mem_im[4]);
    end
    // Untouched-by-value amplitudes at i; zero amplitudes at j pick up -0 in re.
    checks++;
    if (mem_re[0] !== '0 || mem_re[5] !== NZ || mem_im[5] !== '0 || mem_re[7] !== NZ) begin
      failures++;
      $display("FAIL s_zero_sign: re0=%h re5=%h im5=%h re7=%h required 0 80000000 0 80000000",
               mem_re[0], mem_re[5], mem_im[5], mem_re[7]);
    end
    run_cmd(3'd4, 2'd2, 2'd0, cyc, e, en, we, rb);
    checks++;
    for (int a = 0; a < 8; a++) begin
      logic [W-1:0] er, ei;
      er = (a == 4) ? HALF : '0;
      ei = (a == 4) ? ONE  : '0;
      if (mem_re[a] !== er || mem_im[a] !== ei) begin
        failures++;
        $display("FAIL sdg_mem[%0d]: got %h/%h required %h/%h", a, mem_re[a], mem_im[a], er, ei);
      end
    end
  endtask

  task automatic test_y_z();
    int cyc, en, we, rb; logic e;
    mem_clear();
    mem_set(3'd1, HALF, '0);
    run_cmd(3'd1, 2'd0, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (mem_re[0] !== '0 || mem_im[0] !== MHLF || mem_re[1] !== NZ || mem_im[1] !== '0) begin
      failures++;
      $display("FAIL y_pair0: amp0=%h/%h amp1=%h/%h required 0/bf000000 80000000/0",
               mem_re[0], mem_im[0], mem_re[1], mem_im[1]);
    end
    checks++;
    if (mem_re[2] !== '0 || mem_im[2] !== NZ || mem_re[3] !== NZ || mem_im[3] !== '0) begin
      failures++;
      $display("FAIL y_pair1: amp2=%h/%h amp3=%h/%h required 0/80000000 80000000/0",
               mem_re[2], mem_im[2], mem_re[3], mem_im[3]);
    end
    mem_clear();
    mem_set(3'd1, HALF, '0);
    mem_set(3'd0, ONE, '0);
    run_cmd(3'd2, 2'd0, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (mem_re[1] !== MHLF || mem_im[1] !== NZ || mem_re[0] !== ONE || mem_im[0] !== '0) begin
      failures++;
      $display("FAIL z_mem: amp0=%h/%h amp1=%h/%h required 3f800000/0 bf000000/80000000",
               mem_re[0], mem_im[0], mem_re[1], mem_im[1]);
    end
  endtask

  task automatic test_cz();
    int cyc, en, we, rb; logic e;
    mem_clear();
    mem_set(3'd1, ONE, '0);
    mem_set(3'd3, ONE, '0);
    // c=0, t=1: pairs (1,3) and (5,7) qualify; (0,2),(4,6) are skipped.
    run_cmd(3'd6, 2'd1, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (cyc !== 12 || we !== 4) begin
      failures++; $display("FAIL cz_walk: cycles=%0d we=%0d required 12 4", cyc, we);
    end
    checks++;
    if (mem_re[3] !== MONE || mem_im[3] !== NZ || mem_re[7] !== NZ || mem_im[7] !== NZ ||
        mem_re[1] !== ONE || mem_re[2] !== '0 || mem_im[6] !== '0) begin
      failures++;
      $display("FAIL cz_mem: amp3=%h/%h amp7=%h/%h re1=%h re2=%h im6=%h",
               mem_re[3], mem_im[3], mem_re[7], mem_im[7], mem_re[1], mem_re[2], mem_im[6]);
    end
  endtask

  task automatic test_reject();
    int cyc, en, we, rb; logic e;
    logic [2:0]    ops [4] = '{3'd7, 3'd0, 3'd5, 3'd6};
    logic [QW-1:0] tg  [4] = '{2'd0, 2'd3, 2'd1, 2'd0};
    logic [QW-1:0] ct  [4] = '{2'd0, 2'd0, 2'd1, 2'd3};
    mem_clear();
    mem_set(3'd0, ONE, '0);
    for (int v = 0; v < 4; v++) begin
      run_cmd(ops[v], tg[v], ct[v], cyc, e, en, we, rb);
      checks++;
      if (cyc !== 2 || e !== 1'b1 || en !== 0) begin
        failures++;
        $display("FAIL reject[%0d]: cycles=%0d err=%b en=%0d required 2 1 0", v, cyc, e, en);
      end
    end
    checks++;
    if (mem_re[0] !== ONE || mem_re[1] !== '0) begin
      failures++; $display("FAIL reject_mem: re0=%h re1=%h required 3f800000 0", mem_re[0], mem_re[1]);
    end
  endtask

  task automatic test_reset_mid_gate();
    int cyc, en, we, rb; logic e;
    logic seen_wr0;
    mem_clear();
    mem_set(3'd0, ONE, '0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_target = 2'd0; cmd_control = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    // Cycle 1 is CHECK; pair 2 WR0 is cycle 12.
    repeat (11) @(negedge clk);
    seen_wr0 = porta_we && (porta_addr == 3'd4);
    checks++;
    if (!seen_wr0) begin
      failures++; $display("FAIL mid_wr0: we=%b addr=%0d required 1 4", porta_we, porta_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || porta_en !== 1'b0 || porta_we !== 1'b0 || portb_en !== 1'b0 ||
        porta_addr !== '0 || porta_din_re !== '0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: ready=%b aen=%b we=%b ben=%b addr=%0d din=%h done=%b err=%b",
               cmd_ready, porta_en, porta_we, portb_en, porta_addr, porta_din_re, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_clear();
    mem_set(3'd0, ONE, '0);
    run_cmd(3'd0, 2'd0, 2'd0, cyc, e, en, we, rb);
    checks++;
    if (cyc !== 18 || e !== 1'b0 || mem_re[1] !== ONE || mem_re[0] !== '0) begin
      failures++;
      $display("FAIL post_reset_x: cycles=%0d err=%b re0=%h re1=%h required 18 0 0 3f800000",
               cyc, e, mem_re[0], mem_re[1]);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_x();
    test_x_cnot();
    test_s_sdg();
    test_y_z();
    test_cz();
    test_reject();
    test_reset_mid_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
